// File: rtl/fir_ntap_transpose_pkg.sv
// Shared sizing helpers for the N-tap transposed moving-sum filter.
package fir_pkg;

  localparam int TAPS_MAX = 16;
  localparam int W_MAX    = 32;

  // Partial sums hold up to TAPS full-scale samples, so this width never overflows.
  function automatic int calc_ow(input int w, input int taps);
    return w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_ntap_transpose_if.sv
// Sample-in / sum-out bundle for fir_ntap_transpose; the master drives samples.
interface fir_ntap_transpose_if #(
  parameter int W    = 16,
  parameter int TAPS = 4
);
  import fir_pkg::*;

  localparam int OW = calc_ow(W, TAPS);

  logic [W-1:0]  a;
  logic          in_valid;
  logic          flush;
  logic [OW-1:0] s;
  logic          out_valid;
  logic          primed;

  modport master (output a, in_valid, flush, input s, out_valid, primed);
  modport slave  (input a, in_valid, flush, output s, out_valid, primed);
endinterface

// File: rtl/fir_ntap_transpose_rca.sv
// Ripple-carry adder built from per-bit generate/propagate terms; carry-out discarded.
module rca_nbit #(
  parameter int N = 18
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] sum
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] c;

  assign g    = x & y;
  assign p    = x ^ y;
  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i] = p[i] ^ c[i];
    if (i < N - 1) begin : g_carry
      assign c[i+1] = g[i] | (p[i] & c[i]);
    end
  end
endmodule

// File: rtl/fir_ntap_transpose.sv
// Transposed-form N-tap moving-sum FIR with warm-up tracking and synchronous flush.
// Define OUT_PIPE_EN to add one register stage after s/out_valid (primed is not delayed).
module fir_ntap_transpose
  import fir_pkg::*;
#(
  parameter int W    = 16,
  parameter int TAPS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_ntap_transpose_if.slave  bus
);
  localparam int OW = calc_ow(W, TAPS);
  localparam int CW = $clog2(TAPS);
  localparam logic [CW-1:0] CNT_MAX = CW'(TAPS - 1);

  logic [OW-1:0] a_ext;
  logic [OW-1:0] p       [TAPS-1];
  logic [OW-1:0] tap_in  [TAPS];
  logic [OW-1:0] tap_sum [TAPS];
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [OW-1:0] s_q;
  logic          ov_q;
  logic          primed_q;

  assign a_ext = OW'(bus.a);

  // Adder j adds the new sample to p[j]; the last tap has no older partial, so it sees zero.
  for (genvar j = 0; j < TAPS; j++) begin : g_tap
    if (j < TAPS - 1) begin : g_partial
      assign tap_in[j] = p[j];
    end else begin : g_newest
      assign tap_in[j] = '0;
    end
    rca_nbit #(.N(OW)) u_add (.x(a_ext), .y(tap_in[j]), .sum(tap_sum[j]));
  end

  // NOTE: every output of a combinational block gets a default first, so no latch can form.
  always_comb begin
    count_nxt = count;
    if (count != CNT_MAX) count_nxt = count + 1'b1;
  end

  // NOTE: state is updated only with <= so all registers sample pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the partial-sum array is reset explicitly because stale history would leak into s.
      for (int k = 0; k < TAPS - 1; k++) p[k] <= '0;
      count    <= '0;
      primed_q <= 1'b0;
      s_q      <= '0;
      ov_q     <= 1'b0;
    end else if (bus.flush) begin
      for (int k = 0; k < TAPS - 1; k++) p[k] <= '0;
      count    <= '0;
      primed_q <= 1'b0;
      s_q      <= '0;
      ov_q     <= 1'b0;
    end else if (bus.in_valid) begin
      for (int k = 0; k < TAPS - 1; k++) p[k] <= tap_sum[k+1];
      s_q      <= tap_sum[0];
      ov_q     <= (count == CNT_MAX);
      count    <= count_nxt;
      primed_q <= (count_nxt == CNT_MAX);
    end else begin
      ov_q <= 1'b0;
    end
  end

`ifdef OUT_PIPE_EN
  logic [OW-1:0] s_d;
  logic          ov_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_d  <= '0;
      ov_d <= 1'b0;
    end else if (bus.flush) begin
      s_d  <= '0;
      ov_d <= 1'b0;
    end else begin
      s_d  <= s_q;
      ov_d <= ov_q;
    end
  end

  assign bus.s         = s_d;
  assign bus.out_valid = ov_d;
`else
  assign bus.s         = s_q;
  assign bus.out_valid = ov_q;
`endif

  assign bus.primed = primed_q;
endmodule
